pipe_ctrl_unit: RTL and testbench
=================================

# pipe_ctrl_unit

Pipelined main-control unit for the MIPS core: decodes the ID-stage opcode/funct, registers the full control bundle into the ID/EX boundary with stall/flush handling, and sequences the multi-cycle multiply/divide unit. It generalises the combinational main decoder with four additions:
- parametrised mult/div latency;
- illegal-opcode flagging instead of X outputs;
- registered EX controls;
- HI/LO hazard stalls.

## Interface
Parameters:
- MULT_LAT, 4, cycles from MULT/MULTU acceptance to md_done (≥1)
- DIV_LAT, 32, cycles from DIV/DIVU acceptance to md_done (≥1)
- CNT_W, $clog2(max(MULT_LAT,DIV_LAT)), derived localparam, not overridable

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- instr_valid_d  in  1  ID instruction present
- op_d  in  6  opcode
- funct_d  in  6  R-type funct
- stall_e  in  1  EX frozen; hold E register
- flush_e  in  1  insert bubble into E
- stall_d  out  1  freeze IF/ID (HI/LO hazard)
- valid_e, illegal_e  out  1 each
- regwrite_e, alusrc_e, branch_e, bne_e, memwrite_e, memtoreg_e, jump_e, jal_e, lb_e, multordiv_e, hlwrite_e  out  1 each
- regdst_e  out  2
- aluop_e  out  2
- md_busy  out  1  sequencer in BUSY
- md_done  out  1  one-cycle HI/LO write strobe

## Operation
- Decode table (combinational), fields {regwrite,regdst,alusrc,branch,bne,memwrite,memtoreg,jump,jal,lb,multordiv,hlwrite,aluop}:
  - R-type 000000: 1,01,0,0,0,0,0,0,0,0,0,0,10
  - LW 100011: 1,00,1,…,memtoreg=1,aluop 00
  - SW 101011: alusrc=1, memwrite=1
  - BEQ 000100: branch=1, aluop 01
  - BNE 000101: bne=1, aluop 01
  - ADDI 001000: regwrite=1, alusrc=1
  - J 000010: jump=1
  - LB 100000: regwrite, alusrc, memtoreg, lb
  - JAL 000011: regwrite, regdst=10, jump, jal
- R-type funct overrides:
  - MULT/MULTU (011000/011001): regwrite=0, hlwrite=1, multordiv=0.
  - DIV/DIVU (011010/011011): regwrite=0, hlwrite=1, multordiv=1.
  - MFHI/MFLO (010000/010010) are HI/LO readers; normal R-type controls.
- Any other opcode: all controls 0, illegal=1. Never X.
- E register update priority:
  1. reset → all outputs 0.
  2. flush_e → bubble: all controls 0, valid_e=0, illegal_e=0.
  3. stall_e → hold.
  4. stall_d → bubble.
  5. instr_valid_d → load decode, valid_e=1.
  6. Otherwise → bubble.
- Accept = rule 5 taken.
- Mult/div sequencer FSM:
  - IDLE: on accept of an hlwrite op, load cnt with LAT−1 (MULT_LAT or DIV_LAT per multordiv) and go to BUSY.
  - BUSY: cnt decrements each cycle. When cnt==0, assert md_done and go to IDLE.
  - The FSM runs independently of stall_e and flush_e once started.
- stall_d = md_busy & ~md_done & instr_valid_d & (ID op is MULT/DIV family or MFHI/MFLO). Other instructions flow freely.
- No new start while BUSY: stall_d blocks it.

## Timing
- Decode-to-E latency: 1 clock.
- Accept at edge k ⇒ md_done high during cycle k+LAT exactly; md_busy high cycles k+1..k+LAT.
- LAT=1: md_busy and md_done high for the single cycle after acceptance.
- In the md_done cycle, stall_d is low, so a waiting MFHI enters E on the next edge. It reads HI/LO written on the same edge.
- Reset mid-BUSY: next cycle IDLE, cnt=0, md_busy=md_done=stall_d=0, E bubble.
- flush_e together with a MULT in ID: no accept, no start.
- stall_e together with stall_d: E holds (stall_e wins).
- Reset values: every output 0.

## Structure
- ctrl_pkg holds:
  - opcode and funct localparams;
  - ctrl_t packed struct (the 15 control bits);
  - CTRL_NOP constant;
  - function decode(op,funct) returning ctrl_t plus illegal;
  - md_state_t enum {MD_IDLE, MD_BUSY}.
- One sub-module, md_seq: the FSM and counter. It takes start/multordiv and produces md_busy/md_done.
- The top level instantiates md_seq and holds the E register.

## Test plan
- Reset: assert reset 2 cycles with LW in ID → all outputs 0. Release → next edge regwrite_e=1, alusrc_e=1, memtoreg_e=1, valid_e=1.
- Illegal op: op_d=111111 → illegal_e=1, valid_e=1, all other controls 0, no X on any output.
- MULT then MFHI (MULT_LAT=4):
  - MULT accepted at edge 0 → md_busy high cycles 1–4, md_done only in cycle 4.
  - MFHI in ID cycles 1–4 → stall_d=1 in cycles 1–3, 0 in cycle 4.
  - MFHI valid_e at edge 5.
- DIV with an unrelated ADDI stream (DIV_LAT=32) → ADDIs never stall; md_done in cycle 32 exactly. Then DIV_LAT=1 variant → md_done in cycle 1.
- Stall/flush precedence:
  - stall_e=1 three cycles with BEQ in E → BEQ held.
  - flush_e and stall_e simultaneous → bubble.
  - flush_e with MULT in ID → md_busy stays 0.
- Reset at cycle 10 of a 32-cycle DIV → next cycle md_busy=0. md_done never pulses afterward. A new MULT is then accepted normally.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Main-control package: opcode/funct codes, control bundle type, decoder.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] regdst;
    logic       alusrc;
    logic       branch;
    logic       bne;
    logic       memwrite;
    logic       memtoreg;
    logic       jump;
    logic       jal;
    logic       lb;
    logic       multordiv;
    logic       hlwrite;
    logic [1:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  typedef struct packed {
    logic  illegal;
    ctrl_t ctrl;
  } dec_t;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  // Main decoder; unknown opcodes give a clean all-zero bundle plus illegal.
  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct);
    dec_t d;
    d = '0;
    case (op)
      OP_RTYPE: begin
        d.ctrl.regwrite = 1'b1;
        d.ctrl.regdst   = 2'b01;
        d.ctrl.aluop    = 2'b10;
        case (funct)
          FN_MULT, FN_MULTU: begin
            d.ctrl.regwrite  = 1'b0;
            d.ctrl.hlwrite   = 1'b1;
            d.ctrl.multordiv = 1'b0;
          end
          FN_DIV, FN_DIVU: begin
            d.ctrl.regwrite  = 1'b0;
            d.ctrl.hlwrite   = 1'b1;
            d.ctrl.multordiv = 1'b1;
          end
          default: ;
        endcase
      end
      OP_LW: begin
        d.ctrl.regwrite = 1'b1;
        d.ctrl.alusrc   = 1'b1;
        d.ctrl.memtoreg = 1'b1;
      end
      OP_SW: begin
        d.ctrl.alusrc   = 1'b1;
        d.ctrl.memwrite = 1'b1;
      end
      OP_BEQ: begin
        d.ctrl.branch = 1'b1;
        d.ctrl.aluop  = 2'b01;
      end
      OP_BNE: begin
        d.ctrl.bne   = 1'b1;
        d.ctrl.aluop = 2'b01;
      end
      OP_ADDI: begin
        d.ctrl.regwrite = 1'b1;
        d.ctrl.alusrc   = 1'b1;
      end
      OP_J: d.ctrl.jump = 1'b1;
      OP_LB: begin
        d.ctrl.regwrite = 1'b1;
        d.ctrl.alusrc   = 1'b1;
        d.ctrl.memtoreg = 1'b1;
        d.ctrl.lb       = 1'b1;
      end
      OP_JAL: begin
        d.ctrl.regwrite = 1'b1;
        d.ctrl.regdst   = 2'b10;
        d.ctrl.jump     = 1'b1;
        d.ctrl.jal      = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  // True for instructions that touch HI/LO (writers and readers).
  function automatic logic is_hilo_op(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_RTYPE) &&
           (funct == FN_MULT || funct == FN_MULTU || funct == FN_DIV ||
            funct == FN_DIVU || funct == FN_MFHI  || funct == FN_MFLO);
  endfunction

endpackage

// File: rtl/md_seq.sv
// Multiply/divide sequencer: counts the unit latency after a start and
// pulses md_done in the last busy cycle.
module md_seq
  import ctrl_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic multordiv,
  output logic md_busy,
  output logic md_done
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  // Width never collapses to zero when both latencies are 1.
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT - 1);

  md_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] ld_val;

  assign ld_val = multordiv ? DIV_LD : MULT_LD;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state; a start in the done cycle reloads back-to-back.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    md_busy  = (state == MD_BUSY);
    md_done  = 1'b0;
    case (state)
      MD_IDLE: begin
        if (start) begin
          state_nx = MD_BUSY;
          cnt_nx   = ld_val;
        end
      end
      MD_BUSY: begin
        if (cnt == '0) begin
          md_done = 1'b1;
          if (start) begin
            cnt_nx = ld_val;
          end else begin
            state_nx = MD_IDLE;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = MD_IDLE;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined main control: ID decode, ID/EX control register with
// stall/flush, and HI/LO hazard stall against the mult/div sequencer.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid_d,
  input  logic [5:0] op_d,
  input  logic [5:0] funct_d,
  input  logic       stall_e,
  input  logic       flush_e,
  output logic       stall_d,
  output logic       valid_e,
  output logic       illegal_e,
  output logic       regwrite_e,
  output logic       alusrc_e,
  output logic       branch_e,
  output logic       bne_e,
  output logic       memwrite_e,
  output logic       memtoreg_e,
  output logic       jump_e,
  output logic       jal_e,
  output logic       lb_e,
  output logic       multordiv_e,
  output logic       hlwrite_e,
  output logic [1:0] regdst_e,
  output logic [1:0] aluop_e,
  output logic       md_busy,
  output logic       md_done
);

  dec_t  dec_d;
  ctrl_t ctrl_e;
  logic  accept;
  logic  md_start;

  // ID-stage decode and hazard detection.
  always_comb begin
    dec_d   = decode(op_d, funct_d);
    stall_d = md_busy & ~md_done & instr_valid_d & is_hilo_op(op_d, funct_d);
  end

  assign accept   = ~flush_e & ~stall_e & ~stall_d & instr_valid_d;
  assign md_start = accept & dec_d.ctrl.hlwrite;

  // ID/EX control register: reset, flush, hold, hazard bubble, load, bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_e    <= CTRL_NOP;
      valid_e   <= 1'b0;
      illegal_e <= 1'b0;
    end else if (flush_e) begin
      ctrl_e    <= CTRL_NOP;
      valid_e   <= 1'b0;
      illegal_e <= 1'b0;
    end else if (stall_e) begin
      ctrl_e    <= ctrl_e;
      valid_e   <= valid_e;
      illegal_e <= illegal_e;
    end else if (accept) begin
      ctrl_e    <= dec_d.ctrl;
      valid_e   <= 1'b1;
      illegal_e <= dec_d.illegal;
    end else begin
      ctrl_e    <= CTRL_NOP;
      valid_e   <= 1'b0;
      illegal_e <= 1'b0;
    end
  end

  assign regwrite_e  = ctrl_e.regwrite;
  assign regdst_e    = ctrl_e.regdst;
  assign alusrc_e    = ctrl_e.alusrc;
  assign branch_e    = ctrl_e.branch;
  assign bne_e       = ctrl_e.bne;
  assign memwrite_e  = ctrl_e.memwrite;
  assign memtoreg_e  = ctrl_e.memtoreg;
  assign jump_e      = ctrl_e.jump;
  assign jal_e       = ctrl_e.jal;
  assign lb_e        = ctrl_e.lb;
  assign multordiv_e = ctrl_e.multordiv;
  assign hlwrite_e   = ctrl_e.hlwrite;
  assign aluop_e     = ctrl_e.aluop;

  md_seq #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_seq (
    .clk       (clk),
    .reset     (reset),
    .start     (md_start),
    .multordiv (dec_d.ctrl.multordiv),
    .md_busy   (md_busy),
    .md_done   (md_done)
  );

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: default latencies plus a DIV_LAT=1 copy.
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid_d;
  logic [5:0] op_d, funct_d;
  logic       stall_e, flush_e;

  logic       stall_d, valid_e, illegal_e, regwrite_e, alusrc_e, branch_e, bne_e;
  logic       memwrite_e, memtoreg_e, jump_e, jal_e, lb_e, multordiv_e, hlwrite_e;
  logic [1:0] regdst_e, aluop_e;
  logic       md_busy, md_done;

  logic       s2_stall_d, s2_valid_e, s2_illegal_e, s2_regwrite_e, s2_alusrc_e, s2_branch_e, s2_bne_e;
  logic       s2_memwrite_e, s2_memtoreg_e, s2_jump_e, s2_jal_e, s2_lb_e, s2_multordiv_e, s2_hlwrite_e;
  logic [1:0] s2_regdst_e, s2_aluop_e;
  logic       s2_md_busy, s2_md_done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit dut (
    .clk(clk), .reset(reset), .instr_valid_d(instr_valid_d), .op_d(op_d), .funct_d(funct_d),
    .stall_e(stall_e), .flush_e(flush_e), .stall_d(stall_d), .valid_e(valid_e), .illegal_e(illegal_e),
    .regwrite_e(regwrite_e), .alusrc_e(alusrc_e), .branch_e(branch_e), .bne_e(bne_e),
    .memwrite_e(memwrite_e), .memtoreg_e(memtoreg_e), .jump_e(jump_e), .jal_e(jal_e), .lb_e(lb_e),
    .multordiv_e(multordiv_e), .hlwrite_e(hlwrite_e), .regdst_e(regdst_e), .aluop_e(aluop_e),
    .md_busy(md_busy), .md_done(md_done)
  );

  pipe_ctrl_unit #(.MULT_LAT(4), .DIV_LAT(1)) dut_d1 (
    .clk(clk), .reset(reset), .instr_valid_d(instr_valid_d), .op_d(op_d), .funct_d(funct_d),
    .stall_e(stall_e), .flush_e(flush_e), .stall_d(s2_stall_d), .valid_e(s2_valid_e), .illegal_e(s2_illegal_e),
    .regwrite_e(s2_regwrite_e), .alusrc_e(s2_alusrc_e), .branch_e(s2_branch_e), .bne_e(s2_bne_e),
    .memwrite_e(s2_memwrite_e), .memtoreg_e(s2_memtoreg_e), .jump_e(s2_jump_e), .jal_e(s2_jal_e), .lb_e(s2_lb_e),
    .multordiv_e(s2_multordiv_e), .hlwrite_e(s2_hlwrite_e), .regdst_e(s2_regdst_e), .aluop_e(s2_aluop_e),
    .md_busy(s2_md_busy), .md_done(s2_md_done)
  );

  // {valid,illegal,regwrite,regdst,alusrc,branch,bne,memwrite,memtoreg,jump,jal,lb,multordiv,hlwrite,aluop}
  logic [16:0] e_vec;
  assign e_vec = {valid_e, illegal_e, regwrite_e, regdst_e, alusrc_e, branch_e, bne_e, memwrite_e,
                  memtoreg_e, jump_e, jal_e, lb_e, multordiv_e, hlwrite_e, aluop_e};

  localparam logic [16:0] E_NOP  = 17'b0_0_0_00_0_0_0_0_0_0_0_0_0_0_00;
  localparam logic [16:0] E_LW   = 17'b1_0_1_00_1_0_0_0_1_0_0_0_0_0_00;
  localparam logic [16:0] E_ILL  = 17'b1_1_0_00_0_0_0_0_0_0_0_0_0_0_00;
  localparam logic [16:0] E_BEQ  = 17'b1_0_0_00_0_1_0_0_0_0_0_0_0_0_01;
  localparam logic [16:0] E_ADDI = 17'b1_0_1_00_1_0_0_0_0_0_0_0_0_0_00;
  localparam logic [16:0] E_MFHI = 17'b1_0_1_01_0_0_0_0_0_0_0_0_0_0_10;
  localparam logic [16:0] E_MULT = 17'b1_0_0_01_0_0_0_0_0_0_0_0_0_1_10;
  localparam logic [16:0] E_DIV  = 17'b1_0_0_01_0_0_0_0_0_0_0_0_1_1_10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] fn);
    instr_valid_d = v;
    op_d          = op;
    funct_d       = fn;
    #1;
  endtask

  initial begin
    reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    set_id(1'b1, 6'b100011, 6'b000000);  // LW in ID during reset
    tick(); tick();
    chk("reset_e", {15'd0, e_vec}, {15'd0, E_NOP});
    chk("reset_busy", {31'd0, md_busy}, 32'd0);
    chk("reset_done", {31'd0, md_done}, 32'd0);
    chk("reset_stall_d", {31'd0, stall_d}, 32'd0);
    reset = 1'b0;
    tick();
    chk("lw_e", {15'd0, e_vec}, {15'd0, E_LW});

    // Illegal opcode
    set_id(1'b1, 6'b111111, 6'b000000);
    tick();
    chk("illegal_e", {15'd0, e_vec}, {15'd0, E_ILL});

    // MULT then waiting MFHI
    set_id(1'b1, 6'b000000, 6'b011000);
    tick();                               // edge 0: MULT accepted
    set_id(1'b1, 6'b000000, 6'b010000);   // MFHI waits in ID
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("mult_busy_c%0d", c), {31'd0, md_busy}, 32'd1);
      chk($sformatf("mult_done_c%0d", c), {31'd0, md_done}, (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("mfhi_stall_c%0d", c), {31'd0, stall_d}, (c < 4) ? 32'd1 : 32'd0);
      chk($sformatf("mult_e_c%0d", c), {15'd0, e_vec}, (c == 1) ? {15'd0, E_MULT} : {15'd0, E_NOP});
      tick();
    end
    chk("mfhi_e", {15'd0, e_vec}, {15'd0, E_MFHI});
    chk("mult_idle_busy", {31'd0, md_busy}, 32'd0);
    chk("mult_idle_done", {31'd0, md_done}, 32'd0);

    // DIV with an ADDI stream; second instance has DIV_LAT=1
    set_id(1'b1, 6'b000000, 6'b011010);
    tick();                               // edge 0: DIV accepted
    set_id(1'b1, 6'b001000, 6'b000000);
    for (int c = 1; c <= 32; c++) begin
      chk($sformatf("div_busy_c%0d", c), {31'd0, md_busy}, 32'd1);
      chk($sformatf("div_done_c%0d", c), {31'd0, md_done}, (c == 32) ? 32'd1 : 32'd0);
      chk($sformatf("addi_stall_c%0d", c), {31'd0, stall_d}, 32'd0);
      chk($sformatf("div_e_c%0d", c), {15'd0, e_vec}, (c == 1) ? {15'd0, E_DIV} : {15'd0, E_ADDI});
      if (c <= 2) begin
        chk($sformatf("div1_busy_c%0d", c), {31'd0, s2_md_busy}, (c == 1) ? 32'd1 : 32'd0);
        chk($sformatf("div1_done_c%0d", c), {31'd0, s2_md_done}, (c == 1) ? 32'd1 : 32'd0);
      end
      tick();
    end
    chk("div_end_busy", {31'd0, md_busy}, 32'd0);

    // Stall/flush precedence
    set_id(1'b1, 6'b000100, 6'b000000);   // BEQ
    tick();
    chk("beq_e", {15'd0, e_vec}, {15'd0, E_BEQ});
    stall_e = 1'b1;
    set_id(1'b1, 6'b001000, 6'b000000);
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk($sformatf("beq_hold_c%0d", c), {15'd0, e_vec}, {15'd0, E_BEQ});
    end
    flush_e = 1'b1;
    tick();
    chk("flush_over_stall", {15'd0, e_vec}, {15'd0, E_NOP});
    stall_e = 1'b0;
    set_id(1'b1, 6'b000000, 6'b011000);   // MULT under flush
    tick();
    chk("flush_mult_e", {15'd0, e_vec}, {15'd0, E_NOP});
    chk("flush_mult_busy", {31'd0, md_busy}, 32'd0);
    tick();
    chk("flush_mult_busy2", {31'd0, md_busy}, 32'd0);
    flush_e = 1'b0;

    // Reset mid-DIV
    set_id(1'b1, 6'b000000, 6'b011010);
    tick();                               // DIV accepted, now cycle 1
    set_id(1'b0, 6'b000000, 6'b000000);
    for (int c = 2; c <= 10; c++) tick();
    chk("middiv_busy_c10", {31'd0, md_busy}, 32'd1);
    reset = 1'b1;
    tick();
    chk("rst_div_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_div_done", {31'd0, md_done}, 32'd0);
    chk("rst_div_stall", {31'd0, stall_d}, 32'd0);
    chk("rst_div_e", {15'd0, e_vec}, {15'd0, E_NOP});
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      chk($sformatf("no_done_c%0d", c), {30'd0, md_done, md_busy}, 32'd0);
    end
    set_id(1'b1, 6'b000000, 6'b011001);   // MULTU
    tick();
    chk("new_mult_e", {15'd0, e_vec}, {15'd0, E_MULT});
    chk("new_mult_busy", {31'd0, md_busy}, 32'd1);
    set_id(1'b0, 6'b000000, 6'b000000);
    tick(); tick(); tick();
    chk("new_mult_done", {31'd0, md_done}, 32'd1);
    tick();
    chk("new_mult_idle", {31'd0, md_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
